clk_en_gen: RTL and testbench

Parametrised multi-channel fractional clock-enable generator, run from the fabric clock the PLL produces. Each channel is a phase-accumulator NCO that emits single-cycle enable ticks at f_clk·inc/2^ACC_W (e.g. UART ×16 baud). Rates are reprogrammed at runtime through a valid/ready config port. Each channel has a per-channel lock flag modelled on PLL LOCK: it reports when that channel's rate is settled.

---
 rtl/clk_en_gen_if.sv | 41 ++++
 rtl/clk_en_gen.sv | 133 +++++++++++++
 tb/tb_clk_en_gen.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_en_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clk_en_gen_if                                                        |
// | Config handshake and tick/lock outputs of the clock-enable generator |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface clk_en_gen_if #(
    parameter int CHANNELS = 2,
    parameter int ACC_W    = 32
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                cfg_valid;
    logic                cfg_ready;
    logic [CW-1:0]       cfg_chan;
    logic [ACC_W-1:0]    cfg_inc;
    logic                cfg_enable;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] lock;

    modport master (
        output cfg_valid,
        output cfg_chan,
        output cfg_inc,
        output cfg_enable,
        input  cfg_ready,
        input  tick,
        input  lock
    );

    modport slave (
        input  cfg_valid,
        input  cfg_chan,
        input  cfg_inc,
        input  cfg_enable,
        output cfg_ready,
        output tick,
        output lock
    );
endinterface
`default_nettype wire

// File: rtl/clk_en_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clk_en_gen                                                           |
// | Multi-channel phase-accumulator clock-enable generator with per-     |
// | channel lock flags and a runtime valid/ready rate-config port.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module clk_en_gen #(
    parameter int CHANNELS = 2,
    parameter int ACC_W    = 32,
    parameter int SETTLE   = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    clk_en_gen_if.slave  bus
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] c_settle_load = SW'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_ready;
    logic [CW-1:0]      r_chan;
    logic [ACC_W-1:0]   r_inc;
    logic               r_enable;
    logic [SW-1:0]      r_cnt;

    logic               w_accept;
    logic               w_apply;
    logic               w_done;
    logic [CHANNELS-1:0] w_tick;
    logic [CHANNELS-1:0] w_lock;

    assign w_accept = bus.cfg_valid && r_ready;
    assign w_apply  = (r_state == ST_APPLY);
    assign w_done   = (r_state == ST_SETTLE) && (r_cnt == '0);

    // Zero increment is folded into the enable here so channels only see a run/stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_ready  <= 1'b1;
            r_chan   <= '0;
            r_inc    <= '0;
            r_enable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_chan   <= bus.cfg_chan;
                        r_inc    <= bus.cfg_inc;
                        r_enable <= bus.cfg_enable && (bus.cfg_inc != '0);
                        r_ready  <= 1'b0;
                        r_state  <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    r_cnt   <= c_settle_load;
                    r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [ACC_W-1:0] r_acc;
        logic [ACC_W-1:0] r_inc_ch;
        logic             r_en;
        logic             r_tick;
        logic             r_lock;
        logic             w_hit;
        logic [ACC_W:0]   w_sum;

        // Out-of-range channel selects never match, so such configs touch nothing.
        assign w_hit = (r_chan == CW'(i));
        assign w_sum = {1'b0, r_acc} + {1'b0, r_inc_ch};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_acc    <= '0;
                r_inc_ch <= '0;
                r_en     <= 1'b0;
                r_tick   <= 1'b0;
                r_lock   <= 1'b0;
            end else if (w_apply && w_hit) begin
                r_inc_ch <= r_inc;
                r_en     <= r_enable;
                r_acc    <= '0;
                r_tick   <= 1'b0;
                r_lock   <= 1'b0;
            end else begin
                if (r_en) begin
                    r_acc  <= w_sum[ACC_W-1:0];
                    r_tick <= w_sum[ACC_W];
                end else begin
                    r_acc  <= '0;
                    r_tick <= 1'b0;
                end
                if (w_done && w_hit) begin
                    r_lock <= r_en;
                end
            end
        end

        assign w_tick[i] = r_tick;
        assign w_lock[i] = r_lock;
    end

    assign bus.cfg_ready = r_ready;
    assign bus.tick      = w_tick;
    assign bus.lock      = w_lock;

endmodule
`default_nettype wire

// File: tb/tb_clk_en_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_clk_en_gen                                                        |
// | Scoreboard bench for clk_en_gen with an arithmetic NCO reference.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_clk_en_gen;
    localparam int CH = 3;
    localparam int W  = 32;
    localparam int ST = 16;
    localparam int CW = 2;

    typedef struct {
        logic [CH-1:0] tick;
        logic [CH-1:0] lock;
        logic          ready;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb_q[$];
    exp_t mdl_x;
    exp_t mon_x;

    clk_en_gen_if #(.CHANNELS(CH), .ACC_W(W)) bus();

    clk_en_gen #(.CHANNELS(CH), .ACC_W(W), .SETTLE(ST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Reference model: tick k cycles after apply iff floor(k*inc/2^W) steps up.
    longint unsigned m_inc[CH];
    bit              m_en[CH];
    longint          m_start[CH];
    longint          m_lock_edge[CH];
    bit              m_lock_val[CH];
    bit              m_acc_seen;
    longint          m_acc_edge;
    int              m_p_chan;
    longint unsigned m_p_inc;
    bit              m_p_en;
    longint          e_cnt = 0;

    task automatic model_step();
        bit rdy_pre;
        longint unsigned k;
        e_cnt++;
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                m_inc[c] = 0; m_en[c] = 0; m_start[c] = 0;
                m_lock_edge[c] = 0; m_lock_val[c] = 0;
            end
            m_acc_seen = 0;
            mdl_x.tick = '0; mdl_x.lock = '0; mdl_x.ready = 1'b1;
        end else begin
            rdy_pre = !(m_acc_seen && (e_cnt - 1) <= m_acc_edge + ST);
            if (m_acc_seen && e_cnt == m_acc_edge + 1 && m_p_chan < CH) begin
                m_inc[m_p_chan]       = m_p_inc;
                m_en[m_p_chan]        = m_p_en && (m_p_inc != 0);
                m_start[m_p_chan]     = e_cnt;
                m_lock_val[m_p_chan]  = m_p_en && (m_p_inc != 0);
                m_lock_edge[m_p_chan] = e_cnt + ST;
            end
            if (rdy_pre && bus.cfg_valid) begin
                m_acc_seen = 1;
                m_acc_edge = e_cnt;
                m_p_chan   = int'(bus.cfg_chan);
                m_p_inc    = longint'(bus.cfg_inc);
                m_p_en     = bus.cfg_enable;
            end
            mdl_x.ready = !(m_acc_seen && e_cnt <= m_acc_edge + ST);
            for (int c = 0; c < CH; c++) begin
                k = longint'(e_cnt - m_start[c]);
                mdl_x.tick[c] = m_en[c] && k >= 1 &&
                                (((k * m_inc[c]) >> W) != (((k - 1) * m_inc[c]) >> W));
                mdl_x.lock[c] = (e_cnt >= m_lock_edge[c]) ? m_lock_val[c] : 1'b0;
            end
        end
        sb_q.push_back(mdl_x);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL sb_empty: got 0 entries, expected 1");
        end else begin
            mon_x = sb_q.pop_front();
            chk("sb_tick", longint'(bus.tick), longint'(mon_x.tick));
            chk("sb_lock", longint'(bus.lock), longint'(mon_x.lock));
            chk("sb_ready", longint'(bus.cfg_ready), longint'(mon_x.ready));
        end
    end

    task automatic send(input int ch, input longint unsigned inc, input bit en);
        int n;
        n = 0;
        @(negedge clk);
        bus.cfg_valid  = 1'b1;
        bus.cfg_chan   = CW'(ch);
        bus.cfg_inc    = W'(inc);
        bus.cfg_enable = en;
        while (!bus.cfg_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            tests++; fails++;
            $display("FAIL cfg_timeout: got no ready in %0d cycles, expected ready", n);
        end
        @(negedge clk);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (!bus.cfg_ready && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) begin
            tests++; fails++;
            $display("FAIL idle_timeout: got busy %0d cycles, expected ready", n);
        end
    endtask

    task automatic first_tick(input int ch, output int n);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.tick[ch] && n < 100);
    endtask

    task automatic watch(input int ncyc, input int ch, output int cnt,
                         output int gmin, output int gmax, output int lock_low);
        int last;
        int gap;
        last = -1; cnt = 0; gmin = 1 << 30; gmax = 0; lock_low = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            if (bus.tick[ch]) begin
                cnt++;
                if (last >= 0) begin
                    gap = i - last;
                    if (gap < gmin) gmin = gap;
                    if (gap > gmax) gmax = gap;
                end
                last = i;
            end
            if (!bus.lock[ch]) lock_low++;
        end
    endtask

    initial begin
        int n, n2, cnt, gmin, gmax, ll, any, cls;
        longint unsigned finc, rinc, lo;
        bus.cfg_valid = 1'b0; bus.cfg_chan = '0; bus.cfg_inc = '0; bus.cfg_enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tick", longint'(bus.tick), 0);
        chk("rst_lock", longint'(bus.lock), 0);
        chk("rst_ready", longint'(bus.cfg_ready), 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Half rate on ch0
        send(0, 64'h8000_0000, 1'b1);
        fork
            first_tick(0, n);
            wait_idle(n2);
        join
        chk("half_first_tick", n, 3);
        chk("half_ready_low", n2, ST + 1);
        watch(40, 0, cnt, gmin, gmax, ll);
        chk("half_cnt", cnt, 20);
        chk("half_gmin", gmin, 2);
        chk("half_gmax", gmax, 2);
        chk("half_lock_low", ll, 0);

        // Fractional UART x16 rate on ch1
        finc = ((64'd1 << 32) * 64'd1843200 + 64'd62437500) / 64'd124875000;
        send(1, finc, 1'b1);
        wait_idle(n);
        watch(40000, 1, cnt, gmin, gmax, ll);
        lo = (64'd40000 * finc) >> 32;
        chk_rng("frac_cnt", cnt, longint'(lo) - 1, longint'(lo) + 1);
        chk("frac_gmin", gmin, 67);
        chk("frac_gmax", gmax, 68);

        // Isolation: ch0 at quarter rate while ch1 is reprogrammed
        send(0, 64'h4000_0000, 1'b1);
        wait_idle(n);
        fork
            begin
                for (int j = 0; j < 8; j++) send(1, longint'($urandom), 1'($urandom_range(0, 1)));
            end
            watch(300, 0, cnt, gmin, gmax, ll);
        join
        chk("iso_cnt", cnt, 75);
        chk("iso_gmin", gmin, 4);
        chk("iso_gmax", gmax, 4);
        chk("iso_lock_low", ll, 0);

        // Zero increment counts as disabled
        send(2, 0, 1'b1);
        wait_idle(n);
        watch(50, 2, cnt, gmin, gmax, ll);
        chk("zero_cnt", cnt, 0);
        chk("zero_lock_low", ll, 50);

        // Maximum increment
        send(2, 64'hFFFF_FFFF, 1'b1);
        wait_idle(n);
        watch(256, 2, cnt, gmin, gmax, ll);
        chk("max_cnt", cnt, 256);
        chk("max_lock_low", ll, 0);

        // Out-of-range channel
        send(3, 123, 1'b1);
        wait_idle(n);
        chk("oor_ready_low", n, ST + 1);
        watch(40, 0, cnt, gmin, gmax, ll);
        chk("oor_ch0_gap", gmax, 4);
        chk("oor_ch0_lock_low", ll, 0);

        // Held cfg_valid with changing payload: only the accepted value applies
        @(negedge clk);
        bus.cfg_valid = 1'b1; bus.cfg_chan = 2'd1; bus.cfg_inc = 32'h1000_0000; bus.cfg_enable = 1'b1;
        n = 0;
        while (!bus.cfg_ready && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        for (int j = 0; j < ST; j++) begin
            bus.cfg_inc  = $urandom;
            bus.cfg_chan = CW'($urandom_range(0, 3));
            @(negedge clk);
        end
        bus.cfg_valid = 1'b0;
        wait_idle(n);
        watch(64, 1, cnt, gmin, gmax, ll);
        chk("hold_cnt", cnt, 4);
        chk("hold_gap", gmax, 16);
        chk("hold_lock_low", ll, 0);

        // Randomized configs, checked cycle-by-cycle by the scoreboard
        for (int j = 0; j < 12; j++) begin
            cls = $urandom_range(0, 3);
            case (cls)
                0:       rinc = 0;
                1:       rinc = longint'($urandom);
                2:       rinc = longint'($urandom >> $urandom_range(20, 28));
                default: rinc = 64'hFFFF_FFFF - longint'($urandom_range(0, 255));
            endcase
            send($urandom_range(0, 3), rinc, $urandom_range(0, 4) != 0);
            repeat ($urandom_range(5, 150)) @(negedge clk);
        end

        // Reset mid-SETTLE
        send(0, 64'h2000_0000, 1'b1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_tick", longint'(bus.tick), 0);
        chk("arst_lock", longint'(bus.lock), 0);
        chk("arst_ready", longint'(bus.cfg_ready), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        any = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (bus.tick != '0) any++;
        end
        chk("arst_residual_ticks", any, 0);
        chk("arst_lock_after", longint'(bus.lock), 0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
